// File: rtl/llc_set_writeback.sv
// LLC set write-back sequencer: walks the ways of a buffered set, issues one SRAM write per selected way,
// then optionally writes the evict pointer. Define LLC_WB_SKIP_CLEAN_EN to honour way_mask_in (else all ways are written).
module llc_set_writeback #(
  parameter int WAYS       = 16,
  parameter int WAY_BITS   = $clog2(WAYS),
  parameter int SET_BITS   = 9,
  parameter int LINE_BITS  = 128,
  parameter int TAG_BITS   = 20,
  parameter int STATE_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SET_BITS-1:0]   set_in,
  input  logic [WAYS-1:0]       way_mask_in,
  input  logic                  evict_wr_in,
  input  logic [WAY_BITS-1:0]   evict_way_in,
  output logic [WAY_BITS-1:0]   buf_way,
  input  logic [LINE_BITS-1:0]  buf_line,
  input  logic [TAG_BITS-1:0]   buf_tag,
  input  logic [STATE_BITS-1:0] buf_state,
  output logic                  wr_valid,
  output logic                  wr_evict_valid,
  input  logic                  wr_ready,
  output logic [SET_BITS-1:0]   wr_set,
  output logic [WAY_BITS-1:0]   wr_way,
  output logic [LINE_BITS-1:0]  wr_line,
  output logic [TAG_BITS-1:0]   wr_tag,
  output logic [STATE_BITS-1:0] wr_state,
  output logic [WAY_BITS-1:0]   wr_evict_way,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_WRITE, S_EVICT, S_DONE} state_e;

  localparam logic [WAY_BITS-1:0] LAST_WAY = WAY_BITS'(WAYS - 1);

  state_e                state_q, state_d;
  logic [WAY_BITS-1:0]   ptr_q, ptr_d;
  logic [SET_BITS-1:0]   set_q, set_d;
  logic                  evict_wr_q, evict_wr_d;
  logic [WAY_BITS-1:0]   evict_way_q, evict_way_d;
  logic [WAY_BITS-1:0]   wr_way_q, wr_way_d;
  logic [LINE_BITS-1:0]  wr_line_q, wr_line_d;
  logic [TAG_BITS-1:0]   wr_tag_q, wr_tag_d;
  logic [STATE_BITS-1:0] wr_state_q, wr_state_d;
  logic                  wr_valid_q, wr_valid_d;
  logic                  wr_evict_valid_q, wr_evict_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  way_sel;

`ifdef LLC_WB_SKIP_CLEAN_EN
  logic [WAYS-1:0] mask_q, mask_d;
  assign way_sel = mask_q[ptr_q];
`else
  logic unused_mask;
  assign unused_mask = ^way_mask_in;
  assign way_sel     = 1'b1;
`endif

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    set_d       = set_q;
    evict_wr_d  = evict_wr_q;
    evict_way_d = evict_way_q;
    wr_way_d    = wr_way_q;
    wr_line_d   = wr_line_q;
    wr_tag_d    = wr_tag_q;
    wr_state_d  = wr_state_q;
`ifdef LLC_WB_SKIP_CLEAN_EN
    mask_d      = mask_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          set_d       = set_in;
          evict_wr_d  = evict_wr_in;
          evict_way_d = evict_way_in;
`ifdef LLC_WB_SKIP_CLEAN_EN
          mask_d      = way_mask_in;
`endif
          ptr_d       = '0;
          state_d     = S_SCAN;
        end
      end
      S_SCAN: begin
        if (way_sel) begin
          wr_line_d  = buf_line;
          wr_tag_d   = buf_tag;
          wr_state_d = buf_state;
          wr_way_d   = ptr_q;
          state_d    = S_WRITE;
        end else if (ptr_q == LAST_WAY) begin
          state_d = evict_wr_q ? S_EVICT : S_DONE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      S_WRITE: begin
        // Terminal check comes before the increment so ptr never wraps.
        if (wr_ready) begin
          if (ptr_q == LAST_WAY) begin
            state_d = evict_wr_q ? S_EVICT : S_DONE;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = S_SCAN;
          end
        end
      end
      S_EVICT: if (wr_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    wr_valid_d       = (state_d == S_WRITE);
    wr_evict_valid_d = (state_d == S_EVICT);
    busy_d           = (state_d != S_IDLE);
    done_d           = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      ptr_q            <= '0;
      set_q            <= '0;
      evict_wr_q       <= 1'b0;
      evict_way_q      <= '0;
      wr_way_q         <= '0;
      wr_line_q        <= '0;
      wr_tag_q         <= '0;
      wr_state_q       <= '0;
      wr_valid_q       <= 1'b0;
      wr_evict_valid_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
`ifdef LLC_WB_SKIP_CLEAN_EN
      mask_q           <= '0;
`endif
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      set_q            <= set_d;
      evict_wr_q       <= evict_wr_d;
      evict_way_q      <= evict_way_d;
      wr_way_q         <= wr_way_d;
      wr_line_q        <= wr_line_d;
      wr_tag_q         <= wr_tag_d;
      wr_state_q       <= wr_state_d;
      wr_valid_q       <= wr_valid_d;
      wr_evict_valid_q <= wr_evict_valid_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
`ifdef LLC_WB_SKIP_CLEAN_EN
      mask_q           <= mask_d;
`endif
    end
  end

  assign buf_way        = ptr_q;
  assign wr_set         = set_q;
  assign wr_way         = wr_way_q;
  assign wr_line        = wr_line_q;
  assign wr_tag         = wr_tag_q;
  assign wr_state       = wr_state_q;
  assign wr_evict_way   = evict_way_q;
  assign wr_valid       = wr_valid_q;
  assign wr_evict_valid = wr_evict_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_llc_set_writeback.sv
// Directed bench for llc_set_writeback with WAYS=4; expectations follow LLC_WB_SKIP_CLEAN_EN as built.
module tb_llc_set_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  set_in = '0;
  logic [3:0]  way_mask_in = '0;
  logic        evict_wr_in = 1'b0;
  logic [1:0]  evict_way_in = '0;
  logic [1:0]  buf_way;
  logic [31:0] buf_line;
  logic [19:0] buf_tag;
  logic [2:0]  buf_state;
  logic        wr_valid, wr_evict_valid;
  logic        wr_ready = 1'b1;
  logic [8:0]  wr_set;
  logic [1:0]  wr_way, wr_evict_way;
  logic [31:0] wr_line;
  logic [19:0] wr_tag;
  logic [2:0]  wr_state;
  logic        busy, done;

  always #5 clk = ~clk;

  llc_set_writeback #(
    .WAYS(4), .WAY_BITS(2), .SET_BITS(9), .LINE_BITS(32), .TAG_BITS(20), .STATE_BITS(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .set_in(set_in), .way_mask_in(way_mask_in),
    .evict_wr_in(evict_wr_in), .evict_way_in(evict_way_in), .buf_way(buf_way),
    .buf_line(buf_line), .buf_tag(buf_tag), .buf_state(buf_state), .wr_valid(wr_valid),
    .wr_evict_valid(wr_evict_valid), .wr_ready(wr_ready), .wr_set(wr_set), .wr_way(wr_way),
    .wr_line(wr_line), .wr_tag(wr_tag), .wr_state(wr_state), .wr_evict_way(wr_evict_way),
    .busy(busy), .done(done)
  );

  // Set-buffer contents: fixed per-way values.
  function automatic logic [31:0] exp_line(input logic [1:0] w);
    return 32'hA5A5_0000 + 32'(w) * 32'h0000_0101;
  endfunction
  function automatic logic [19:0] exp_tag(input logic [1:0] w);
    return 20'hBEE00 + 20'(w);
  endfunction
  function automatic logic [2:0] exp_state(input logic [1:0] w);
    return 3'(w) + 3'd3;
  endfunction

  assign buf_line  = exp_line(buf_way);
  assign buf_tag   = exp_tag(buf_way);
  assign buf_state = exp_state(buf_way);

  function automatic bit sel(input logic [3:0] m, input int w);
`ifdef LLC_WB_SKIP_CLEAN_EN
    return m[w];
`else
    return 1'b1;
`endif
  endfunction

  // Cycle (relative to the start edge T) in which done is expected.
  function automatic int exp_done(input logic [3:0] m, input logic ev, input int stall);
    int c = 0;
    for (int w = 0; w < 4; w++) c += sel(m, w) ? 2 : 1;
    return c + (ev ? 1 : 0) + stall + 1;
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  int          done_cycle, evict_cycle, done_cnt, both_cnt;
  logic        busy_first, busy_after, stall_changed;
  logic [1:0]  ev_way_seen;
  logic [1:0]  q_way[$];
  logic [8:0]  q_set[$];
  logic [31:0] q_line[$];
  logic [19:0] q_tag[$];
  logic [2:0]  q_state[$];

  // Drives one operation and records what the DUT did; comparisons live in the test tasks.
  task automatic run_op(input logic [8:0] s, input logic [3:0] m, input logic ev,
                        input logic [1:0] evw, input int stall, input int inject);
    int stall_cnt = 0;
    bit snap_act  = 1'b0;
    logic [63:0] snap = '0;
    done_cycle = -1; evict_cycle = -1; done_cnt = 0; both_cnt = 0;
    busy_first = 1'b0; busy_after = 1'b1; stall_changed = 1'b0; ev_way_seen = '0;
    q_way.delete(); q_set.delete(); q_line.delete(); q_tag.delete(); q_state.delete();
    @(negedge clk);
    start = 1'b1; set_in = s; way_mask_in = m; evict_wr_in = ev; evict_way_in = evw; wr_ready = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = (k == inject);
      if (k == inject) begin
        set_in = 9'h1FF; way_mask_in = ~m; evict_wr_in = ~ev; evict_way_in = ~evw;
      end
      if (k == 1) busy_first = busy;
      if (done_cycle >= 0 && k == done_cycle + 1) busy_after = busy;
      if (wr_valid && wr_evict_valid) both_cnt++;
      if (wr_valid && stall_cnt < stall) begin
        wr_ready = 1'b0;
        if (!snap_act) begin
          snap_act = 1'b1;
          snap = {wr_way, wr_set, wr_line, wr_tag, wr_state};
        end else if ({wr_way, wr_set, wr_line, wr_tag, wr_state} != snap) begin
          stall_changed = 1'b1;
        end
        stall_cnt++;
      end else begin
        wr_ready = 1'b1;
        if (snap_act && wr_valid) begin
          if ({wr_way, wr_set, wr_line, wr_tag, wr_state} != snap) stall_changed = 1'b1;
          snap_act = 1'b0;
        end
      end
      if (wr_valid && wr_ready) begin
        q_way.push_back(wr_way); q_set.push_back(wr_set); q_line.push_back(wr_line);
        q_tag.push_back(wr_tag); q_state.push_back(wr_state);
      end
      if (wr_evict_valid && wr_ready && evict_cycle < 0) begin
        evict_cycle = k; ev_way_seen = wr_evict_way;
      end
      if (done) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = k;
      end
      if (done_cycle >= 0 && k >= done_cycle + 1) break;
    end
    wr_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({wr_valid, wr_evict_valid, busy, done} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {wr_valid, wr_evict_valid, busy, done});
    end
    n_checks++;
    if ({buf_way, wr_set, wr_way, wr_line, wr_tag, wr_state, wr_evict_way} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0",
                         {buf_way, wr_set, wr_way, wr_line, wr_tag, wr_state, wr_evict_way});
    end
    rst = 1'b0;
  endtask

  task automatic test_full_set();
    run_op(9'h01A, 4'b1111, 1'b0, 2'd0, 0, 0);
    n_checks++;
    if (q_way.size() != 4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", q_way.size()); end
    for (int i = 0; i < q_way.size(); i++) begin
      n_checks++;
      if (q_way[i] !== 2'(i) || q_set[i] !== 9'h01A) begin
        n_fail++; $display("FAIL full_way_set[%0d]: got way %0d set %h expected way %0d set 01a", i, q_way[i], q_set[i], i);
      end
      n_checks++;
      if ({q_line[i], q_tag[i], q_state[i]} !== {exp_line(2'(i)), exp_tag(2'(i)), exp_state(2'(i))}) begin
        n_fail++; $display("FAIL full_data[%0d]: got %h/%h/%h expected %h/%h/%h", i, q_line[i], q_tag[i], q_state[i],
                           exp_line(2'(i)), exp_tag(2'(i)), exp_state(2'(i)));
      end
    end
    n_checks++;
    if (done_cycle != 9) begin n_fail++; $display("FAIL full_done_cycle: got %0d expected 9", done_cycle); end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL full_done_pulses: got %0d expected 1", done_cnt); end
    n_checks++;
    if ({busy_first, busy_after} !== 2'b10) begin
      n_fail++; $display("FAIL full_busy: got first %b after %b expected 1 0", busy_first, busy_after);
    end
    n_checks++;
    if (both_cnt != 0) begin n_fail++; $display("FAIL full_exclusive: got %0d overlaps expected 0", both_cnt); end
  endtask

  task automatic test_sparse_stall();
    logic [1:0] ways[$];
    for (int w = 0; w < 4; w++) if (sel(4'b0100, w)) ways.push_back(2'(w));
    run_op(9'h0C3, 4'b0100, 1'b0, 2'd0, 3, 0);
    n_checks++;
    if (q_way.size() != ways.size()) begin
      n_fail++; $display("FAIL sparse_count: got %0d expected %0d", q_way.size(), ways.size());
    end
    for (int i = 0; i < q_way.size() && i < ways.size(); i++) begin
      n_checks++;
      if ({q_way[i], q_set[i], q_line[i]} !== {ways[i], 9'h0C3, exp_line(ways[i])}) begin
        n_fail++; $display("FAIL sparse_write[%0d]: got way %0d set %h line %h expected way %0d set 0c3 line %h",
                           i, q_way[i], q_set[i], q_line[i], ways[i], exp_line(ways[i]));
      end
    end
    n_checks++;
    if (stall_changed !== 1'b0) begin n_fail++; $display("FAIL sparse_stable: outputs changed during stall"); end
    n_checks++;
    if (done_cycle != exp_done(4'b0100, 1'b0, 3)) begin
      n_fail++; $display("FAIL sparse_done_cycle: got %0d expected %0d", done_cycle, exp_done(4'b0100, 1'b0, 3));
    end
  endtask

  task automatic test_evict_only();
    int nsel = 0;
    for (int w = 0; w < 4; w++) if (sel(4'b0000, w)) nsel++;
    run_op(9'h133, 4'b0000, 1'b1, 2'd3, 0, 0);
    n_checks++;
    if (q_way.size() != nsel) begin n_fail++; $display("FAIL evict_writes: got %0d expected %0d", q_way.size(), nsel); end
    n_checks++;
    if (evict_cycle != exp_done(4'b0000, 1'b1, 0) - 1 || ev_way_seen !== 2'd3) begin
      n_fail++; $display("FAIL evict_req: got cycle %0d way %0d expected cycle %0d way 3",
                         evict_cycle, ev_way_seen, exp_done(4'b0000, 1'b1, 0) - 1);
    end
    n_checks++;
    if (done_cycle != exp_done(4'b0000, 1'b1, 0)) begin
      n_fail++; $display("FAIL evict_done_cycle: got %0d expected %0d", done_cycle, exp_done(4'b0000, 1'b1, 0));
    end
    n_checks++;
    if (both_cnt != 0) begin n_fail++; $display("FAIL evict_exclusive: got %0d overlaps expected 0", both_cnt); end
  endtask

  task automatic test_reset_mid_write();
    bit seen = 1'b0, saw_done = 1'b0, saw_busy = 1'b0;
    @(negedge clk);
    start = 1'b1; set_in = 9'h077; way_mask_in = 4'b1111; evict_wr_in = 1'b1; evict_way_in = 2'd2;
    wr_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (wr_valid) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rstmid_wr_valid: got no wr_valid expected wr_valid within 10 cycles"); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({wr_valid, wr_evict_valid, busy, done, buf_way, wr_set, wr_way, wr_line, wr_tag, wr_state, wr_evict_way} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %h expected 0",
                         {wr_valid, wr_evict_valid, busy, done, buf_way, wr_set, wr_way, wr_line, wr_tag, wr_state, wr_evict_way});
    end
    rst = 1'b0; wr_ready = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    n_checks++;
    if ({saw_done, saw_busy} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_idle: got done %b busy %b expected 0 0", saw_done, saw_busy);
    end
    run_op(9'h100, 4'b1010, 1'b0, 2'd0, 0, 0);
    n_checks++;
    if (done_cycle != exp_done(4'b1010, 1'b0, 0)) begin
      n_fail++; $display("FAIL rstmid_restart: got done cycle %0d expected %0d", done_cycle, exp_done(4'b1010, 1'b0, 0));
    end
  endtask

  task automatic test_start_while_busy();
    logic [1:0] ways[$];
    for (int w = 0; w < 4; w++) if (sel(4'b0011, w)) ways.push_back(2'(w));
    run_op(9'h055, 4'b0011, 1'b0, 2'd0, 0, 2);
    n_checks++;
    if (q_way.size() != ways.size()) begin
      n_fail++; $display("FAIL busy_count: got %0d expected %0d", q_way.size(), ways.size());
    end
    for (int i = 0; i < q_way.size() && i < ways.size(); i++) begin
      n_checks++;
      if ({q_way[i], q_set[i]} !== {ways[i], 9'h055}) begin
        n_fail++; $display("FAIL busy_write[%0d]: got way %0d set %h expected way %0d set 055", i, q_way[i], q_set[i], ways[i]);
      end
    end
    n_checks++;
    if (done_cycle != exp_done(4'b0011, 1'b0, 0) || evict_cycle != -1) begin
      n_fail++; $display("FAIL busy_done: got done %0d evict %0d expected done %0d evict -1",
                         done_cycle, evict_cycle, exp_done(4'b0011, 1'b0, 0));
    end
  endtask

  task automatic test_mask_one();
    logic [1:0] ways[$];
    for (int w = 0; w < 4; w++) if (sel(4'b0001, w)) ways.push_back(2'(w));
    run_op(9'h1F0, 4'b0001, 1'b0, 2'd0, 0, 0);
    n_checks++;
    if (q_way.size() != ways.size()) begin
      n_fail++; $display("FAIL mask1_count: got %0d expected %0d", q_way.size(), ways.size());
    end
    for (int i = 0; i < q_way.size() && i < ways.size(); i++) begin
      n_checks++;
      if ({q_way[i], q_tag[i], q_state[i]} !== {ways[i], exp_tag(ways[i]), exp_state(ways[i])}) begin
        n_fail++; $display("FAIL mask1_write[%0d]: got way %0d tag %h state %0d expected way %0d", i, q_way[i], q_tag[i], q_state[i], ways[i]);
      end
    end
    n_checks++;
    if (done_cycle != exp_done(4'b0001, 1'b0, 0)) begin
      n_fail++; $display("FAIL mask1_done_cycle: got %0d expected %0d", done_cycle, exp_done(4'b0001, 1'b0, 0));
    end
  endtask

  initial begin
    test_reset();
    test_full_set();
    test_sparse_stall();
    test_evict_only();
    test_reset_mid_write();
    test_start_while_busy();
    test_mask_one();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/llc_set_writeback.md
# llc_set_writeback

Write-back sequencer for the LLC set buffers. After a request has been serviced out of the per-set buffers, it walks the ways of the buffered set and issues one SRAM write per selected way (line, tag, state), then optionally writes the evict-way pointer. It sits between the set buffers, which it indexes through `buf_way`, and the LLC SRAM write port, which it drives through a valid/ready handshake.

## Interface
Parameters:
- `WAYS`, 16, ways per set; must be a power of two and at least 2.
- `WAY_BITS`, $clog2(WAYS), way index width.
- `SET_BITS`, 9, set index width.
- `LINE_BITS`, 128, line data width.
- `TAG_BITS`, 20, tag width.
- `STATE_BITS`, 3, state width.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all flops on rising edge.
- `rst` in 1: synchronous active-high reset.
- `start` in 1: single-cycle request; accepted only in IDLE.
- `set_in` in SET_BITS: set to write back; latched on accepted `start`.
- `way_mask_in` in WAYS: ways to write; latched on accepted `start`.
- `evict_wr_in` in 1: also write the evict pointer; latched on accepted `start`.
- `evict_way_in` in WAY_BITS: evict pointer value; latched on accepted `start`.
- `buf_way` out WAY_BITS: selects the set-buffer entry.
- `buf_line` in LINE_BITS: line of the buffer entry selected by `buf_way`, valid in the same cycle.
- `buf_tag` in TAG_BITS: tag of the same entry.
- `buf_state` in STATE_BITS: state of the same entry.
- `wr_valid` out 1: line/tag/state write request.
- `wr_evict_valid` out 1: evict-pointer write request.
- `wr_ready` in 1: SRAM accepts the current request; shared by both request types.
- `wr_set` out SET_BITS: set of the current request.
- `wr_way` out WAY_BITS: way of the line/tag/state write.
- `wr_line` out LINE_BITS: line of the line/tag/state write.
- `wr_tag` out TAG_BITS: tag of the line/tag/state write.
- `wr_state` out STATE_BITS: state of the line/tag/state write.
- `wr_evict_way` out WAY_BITS: evict-pointer value.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
States: IDLE, SCAN, WRITE, EVICT, DONE.
- **IDLE:**
  - On `start`: latch all `*_in` inputs, clear `ptr` to 0, go to SCAN.
  - `start` is ignored in every other state.
- **SCAN:**
  - `buf_way` equals `ptr`.
  - If way `ptr` is selected: register `buf_line`, `buf_tag` and `buf_state` into `wr_line`, `wr_tag` and `wr_state`; set `wr_way` to `ptr`; go to WRITE.
  - Else, if `ptr` is WAYS-1: go to EVICT when the latched evict flag is set, otherwise to DONE.
  - Else: increment `ptr` and stay in SCAN.
- **WRITE:**
  - `wr_valid` is 1.
  - All `wr_*` outputs stay stable until `wr_ready`.
  - On `wr_ready`: if `ptr` is WAYS-1, go to EVICT or DONE as in SCAN; otherwise increment `ptr` and go to SCAN.
- **EVICT:**
  - `wr_evict_valid` is 1 and `wr_evict_way` holds the latched pointer.
  - On `wr_ready`: go to DONE.
- **DONE:** `done` is 1 for this one cycle; go to IDLE.
- **Arithmetic:** `ptr` is WAY_BITS wide and never wraps; the terminal check at WAYS-1 precedes any increment.
- **`wr_ready`:** ignored in IDLE, SCAN and DONE.
- **Valid exclusivity:** `wr_valid` and `wr_evict_valid` are never high together.
- **Reset values:**
  - All outputs are 0 and the state is IDLE.
  - Reset mid-operation drops any pending request with no completion pulse: `wr_valid` and `wr_evict_valid` fall on the next edge.
- **Empty selection:** no ways selected and no evict write still runs WAYS SCAN cycles, then DONE.

## Timing
- `start` sampled at edge T: SCAN of way 0 occurs in cycle T+1.
- Each selected way costs 2 cycles (SCAN then WRITE) plus any `wr_ready` stall.
- Each unselected way costs 1 cycle.
- With all ways selected, `wr_ready` held at 1 and no evict write: `done` in cycle T+2·WAYS+1.
- With an evict write added: `done` in cycle T+2·WAYS+2.
- Buffer data is sampled in the SCAN cycle. The set buffers must not change between accepted `start` and `done`.
- `busy` rises in cycle T+1 and falls in the cycle after `done`.

## Configuration
- `LLC_WB_SKIP_CLEAN_EN` defined: only ways whose bit is set in the latched `way_mask_in` are written.
- `LLC_WB_SKIP_CLEAN_EN` undefined:
  - Every way is selected and the mask is ignored.
  - Always WAYS writes per operation; latency is fixed at the all-selected figure.

## Test plan
All scenarios use WAYS=4 and the macro defined unless noted.
- **Full set, no stalls:** start with set 0x1A, mask 4'b1111, no evict, `wr_ready` held at 1 → four writes with `wr_way` 0,1,2,3, all with `wr_set`=0x1A and data matching the buffer entries; `done` in cycle T+9.
- **Sparse mask with stall:** mask 4'b0100, `wr_ready` low for 3 cycles → a single write, `wr_way`=2, outputs stable throughout the stall; `done` in cycle T+9.
- **Evict only:** mask 4'b0000, evict flag 1, evict way 3 → no `wr_valid`; `wr_evict_valid` with `wr_evict_way`=3 in cycle T+5; `done` in cycle T+6.
- **Reset mid-write:** assert `rst` while `wr_valid` is 1 → next cycle every output is 0, state is IDLE, no `done`; a new `start` then completes normally.
- **Start while busy:** assert `start` with different set and mask during WRITE → ignored; the original set and mask complete unchanged.
- **Macro undefined:** mask 4'b0001 → four writes, ways 0–3; `done` in cycle T+9.
